aemb2_issue_ctrl: RTL and testbench
===================================

AEMB2_ISSUE_CTRL -- requirements
Module: aemb2_issue_ctrl

Interface
REQ-001 SHALL have parameter TXE, default 1: 1 = two interleaved hardware threads, 0 = single thread.
REQ-002 SHALL have clk_i  in  1  pipeline clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have iwb_ack_i  in  1  instruction fetch complete.
REQ-005 SHALL have dwb_stb_i  in  1  EX stage has a data access outstanding.
REQ-006 SHALL have dwb_ack_i  in  1  data access complete.
REQ-007 SHALL have fLOD_EX  in  1  instruction in EX is a load.
REQ-008 SHALL have rRD_EX  in  5  EX destination register.
REQ-009 SHALL have rRA_IF, rRB_IF  in  5 each  IF source registers.
REQ-010 SHALL have fIMM_IF  in  1  IF operand B is immediate, so rRB_IF is unused.
REQ-011 SHALL have rBRA  in  2  branch status from EX; 2'b10 = taken branch without delay slot.
REQ-012 SHALL have ena_o  out  1  pipeline advance enable.
REQ-013 SHALL have pha_o  out  1  thread phase for the current cycle.
REQ-014 SHALL have skp_o  out  1  squash the instruction currently in IF.
REQ-015 SHALL have iwb_stb_o  out  1  instruction fetch request.
REQ-016 SHALL have state_o  out  2  FSM state: 0 RUN, 1 WAIT_I, 2 WAIT_D, 3 HAZ.

Function
REQ-017 SHALL compute dok = !dwb_stb_i | dwb_ack_i.
REQ-018 SHALL compute haz = fLOD_EX & (rRD_EX != 0) & (TXE == 0) & ((rRA_IF == rRD_EX) | (!fIMM_IF & (rRB_IF == rRD_EX))).
REQ-019 SHALL drive ena_o = iwb_ack_i & dok & (state == HAZ | !haz), combinationally.
REQ-020 SHALL make FSM transitions, evaluated in every state:
  - !dok -> WAIT_D;
  - else !iwb_ack_i -> WAIT_I;
  - else haz and state is not HAZ -> HAZ;
  - else -> RUN.
REQ-021 SHALL ignore haz while in HAZ, so a load-use bubble lasts exactly one cycle even though the frozen EX still matches.
REQ-022 SHALL toggle pha_o on each cycle with ena_o=1 when TXE=1, and hold pha_o at 1 when TXE=0.
REQ-023 SHALL keep a 2-bit skip shift register that advances only on ena_o=1 cycles:
  - shift-in value = (rBRA == 2'b10);
  - skp_o = bit[TXE], so the squash lands on the same thread's next issue: 1 enabled cycle later for TXE=0, 2 for TXE=1.
REQ-024 SHALL hold skp_o stable while ena_o=0.
REQ-025 SHALL, when rBRA == 2'b10 on consecutive enabled cycles (TXE=1, both threads), squash each thread's next slot independently.
REQ-026 SHALL give simultaneous data wait and fetch wait priority to WAIT_D; state_o reports WAIT_D.
REQ-027 SHALL drive iwb_stb_o 0 in reset, then 1 from the first clock edge after reset release.

Reset
REQ-028 SHALL, while rst_i=0, immediately force:
  - state = RUN;
  - pha_o = 1;
  - skip register = 2'b00, so skp_o = 0;
  - iwb_stb_o = 0.
REQ-029 SHALL force ena_o = 0 while rst_i=0, regardless of inputs.
REQ-030 SHALL, on reset asserted mid-WAIT/HAZ, discard that state with no pending squash or phase carried over.

Configuration
REQ-031 SHALL use macro AEMB2_LDUSE_INTLK_EN to compile in the load-use interlock.
REQ-032 SHALL, when AEMB2_LDUSE_INTLK_EN is defined, behave per REQ-018..021.
REQ-033 SHALL, when AEMB2_LDUSE_INTLK_EN is undefined:
  - tie haz to 0 and never enter HAZ (state 3 unused);
  - make software responsible for load-use scheduling.

Verification
REQ-034 SHALL cover reset release with all acks high and TXE=1 -> iwb_stb_o=1 next edge; ena_o=1 every cycle; pha_o sequence 1,0,1,0.
REQ-035 SHALL cover dwb_stb_i=1 with dwb_ack_i low for 3 cycles -> state_o=2 and ena_o=0 for 3 cycles; pha_o frozen; RUN after ack.
REQ-036 SHALL cover TXE=0, interlock on, fLOD_EX=1, rRD_EX=5, rRA_IF=5 -> exactly one ena_o=0 cycle with state_o=3, then ena_o=1.
REQ-037 SHALL cover the REQ-036 stimulus with rRD_EX=0, or with fIMM_IF=1 and only rRB_IF=5 matching -> no stall.
REQ-038 SHALL cover TXE=1, rBRA=2'b10 on one enabled cycle -> skp_o=1 exactly on the second following enabled cycle, same pha_o value.
REQ-039 SHALL cover iwb_ack_i low and dwb wait in the same cycle, then rst_i pulsed low -> state_o=2 before reset; all outputs at reset values asynchronously.

Source files
------------

// File: rtl/aemb2_issue_ctrl_if.sv
// Issue-control bundle for aemb2_issue_ctrl: fetch/data handshakes,
// hazard inputs from the IF/EX stages and the issue controls back out.
// slave  = the issue controller's view, master = the pipeline's view.
interface aemb2_issue_ctrl_if;
    logic       iwb_ack_i;
    logic       dwb_stb_i;
    logic       dwb_ack_i;
    logic       fLOD_EX;
    logic [4:0] rRD_EX;
    logic [4:0] rRA_IF;
    logic [4:0] rRB_IF;
    logic       fIMM_IF;
    logic [1:0] rBRA;
    logic       ena_o;
    logic       pha_o;
    logic       skp_o;
    logic       iwb_stb_o;
    logic [1:0] state_o;

    modport slave (
        input  iwb_ack_i, dwb_stb_i, dwb_ack_i, fLOD_EX,
        input  rRD_EX, rRA_IF, rRB_IF, fIMM_IF, rBRA,
        output ena_o, pha_o, skp_o, iwb_stb_o, state_o
    );

    modport master (
        output iwb_ack_i, dwb_stb_i, dwb_ack_i, fLOD_EX,
        output rRD_EX, rRA_IF, rRB_IF, fIMM_IF, rBRA,
        input  ena_o, pha_o, skp_o, iwb_stb_o, state_o
    );
endinterface

// File: rtl/aemb2_issue_ctrl.sv
// aemb2_issue_ctrl: pipeline issue controller. Stalls the pipe on fetch or
// data waits, optionally inserts a one-cycle load-use bubble, alternates the
// thread phase and squashes the slot after a taken no-delay-slot branch.
// Optional feature macro: AEMB2_LDUSE_INTLK_EN (load-use interlock).
module aemb2_issue_ctrl #(
    parameter int TXE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    aemb2_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2,
        ST_HAZ    = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       dok_s;
    logic       haz_s;
    logic       ena_s;
    logic       pha_r;
    logic       stb_r;
    logic [1:0] skip_r;

    assign dok_s = ~bus.dwb_stb_i | bus.dwb_ack_i;

`ifdef AEMB2_LDUSE_INTLK_EN
    // A load in EX feeding either IF source register needs a bubble; with
    // two interleaved threads the other thread's slot already covers it.
    assign haz_s = bus.fLOD_EX & (bus.rRD_EX != 5'd0) & (TXE == 0) &
                   ((bus.rRA_IF == bus.rRD_EX) |
                    (~bus.fIMM_IF & (bus.rRB_IF == bus.rRD_EX)));
`else
    // Load-use scheduling is left to software; hazard inputs are not needed.
    logic unused_haz_s;
    assign unused_haz_s = ^{bus.fLOD_EX, bus.rRD_EX, bus.rRA_IF,
                            bus.rRB_IF, bus.fIMM_IF};
    assign haz_s = 1'b0;
`endif

    // In HAZ the frozen EX still matches, so the hazard is ignored there to
    // keep the bubble at exactly one cycle. Reset forces the pipe to hold.
    assign ena_s = rst_i & bus.iwb_ack_i & dok_s & ((state_r == ST_HAZ) | ~haz_s);

    // Next-state selection; data wait outranks fetch wait outranks hazard.
    always_comb begin
        state_nxt_s = ST_RUN;
        if (!dok_s) begin
            state_nxt_s = ST_WAIT_D;
        end else if (!bus.iwb_ack_i) begin
            state_nxt_s = ST_WAIT_I;
        end else if (haz_s && (state_r != ST_HAZ)) begin
            state_nxt_s = ST_HAZ;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // State register; reset discards any wait or bubble in progress.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Thread phase flips on every issued slot when two threads interleave.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pha_r <= 1'b1;
        end else if (ena_s) begin
            pha_r <= (TXE != 0) ? ~pha_r : 1'b1;
        end else begin
            pha_r <= pha_r;
        end
    end

    // Squash history: one bit per issued slot, so a squash lands on the
    // same thread's next issue however long the pipe stalls in between.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skip_r <= 2'b00;
        end else if (ena_s) begin
            skip_r <= {skip_r[0], (bus.rBRA == 2'b10)};
        end else begin
            skip_r <= skip_r;
        end
    end

    // Fetch request stays low in reset and rises on the first edge after.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stb_r <= 1'b0;
        end else begin
            stb_r <= 1'b1;
        end
    end

    assign bus.ena_o     = ena_s;
    assign bus.pha_o     = pha_r;
    assign bus.skp_o     = (TXE != 0) ? skip_r[1] : skip_r[0];
    assign bus.iwb_stb_o = stb_r;
    assign bus.state_o   = state_r;
endmodule

// File: tb/tb_aemb2_issue_ctrl.sv
// Randomised self-checking bench for aemb2_issue_ctrl. Two instances run
// side by side: index 0 with TXE=0, index 1 with TXE=1, on the same stimulus.
module tb_aemb2_issue_ctrl;
`ifdef AEMB2_LDUSE_INTLK_EN
    localparam bit INTLK = 1'b1;
`else
    localparam bit INTLK = 1'b0;
`endif
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    aemb2_issue_ctrl_if bus0 ();
    aemb2_issue_ctrl_if bus1 ();

    aemb2_issue_ctrl #(.TXE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    aemb2_issue_ctrl #(.TXE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: instance index doubles as its TXE value.
    int m_state [2];
    int m_cnt   [2];          // issued (enabled) slots since reset
    bit m_stb   [2];
    bit br_log  [2][LOGN];    // taken-no-delay-branch flag per issued slot

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_haz(input int i, input bit lod, input logic [4:0] rd,
                                 input logic [4:0] ra, input logic [4:0] rb, input bit imm);
        return INTLK && (i == 0) && lod && (rd != 5'd0) &&
               ((ra == rd) || (!imm && (rb == rd)));
    endfunction

    function automatic int m_pha(input int i);
        return (i == 1) ? ((m_cnt[i] % 2 == 0) ? 1 : 0) : 1;
    endfunction

    function automatic int m_skp(input int i);
        int lag;
        lag = (i == 1) ? 2 : 1;
        return (m_cnt[i] >= lag) ? int'(br_log[i][(m_cnt[i] - lag) % LOGN]) : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
            m_stb[i]   = 1'b0;
        end
    endtask

    task automatic drive(input bit iack, input bit dstb, input bit dack, input bit lod,
                         input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                         input bit imm, input logic [1:0] bra);
        bus0.iwb_ack_i = iack; bus1.iwb_ack_i = iack;
        bus0.dwb_stb_i = dstb; bus1.dwb_stb_i = dstb;
        bus0.dwb_ack_i = dack; bus1.dwb_ack_i = dack;
        bus0.fLOD_EX   = lod;  bus1.fLOD_EX   = lod;
        bus0.rRD_EX    = rd;   bus1.rRD_EX    = rd;
        bus0.rRA_IF    = ra;   bus1.rRA_IF    = ra;
        bus0.rRB_IF    = rb;   bus1.rRB_IF    = rb;
        bus0.fIMM_IF   = imm;  bus1.fIMM_IF   = imm;
        bus0.rBRA      = bra;  bus1.rBRA      = bra;
    endtask

    task automatic check_outputs(input string pfx, input int e_ena[2]);
        check_eq({pfx, "_ena0"},   bus0.ena_o,     e_ena[0]);
        check_eq({pfx, "_ena1"},   bus1.ena_o,     e_ena[1]);
        check_eq({pfx, "_state0"}, bus0.state_o,   m_state[0]);
        check_eq({pfx, "_state1"}, bus1.state_o,   m_state[1]);
        check_eq({pfx, "_pha0"},   bus0.pha_o,     m_pha(0));
        check_eq({pfx, "_pha1"},   bus1.pha_o,     m_pha(1));
        check_eq({pfx, "_skp0"},   bus0.skp_o,     m_skp(0));
        check_eq({pfx, "_skp1"},   bus1.skp_o,     m_skp(1));
        check_eq({pfx, "_stb0"},   bus0.iwb_stb_o, m_stb[0]);
        check_eq({pfx, "_stb1"},   bus1.iwb_stb_o, m_stb[1]);
    endtask

    // One clock cycle: drive after the falling edge, check, then advance model.
    task automatic step(input bit iack, input bit dstb, input bit dack, input bit lod,
                        input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                        input bit imm, input logic [1:0] bra);
        int  e_ena [2];
        int  nxt   [2];
        bit  dok, hz;
        @(negedge clk);
        drive(iack, dstb, dack, lod, rd, ra, rb, imm, bra);
        #1;
        dok = !dstb || dack;
        for (int i = 0; i < 2; i++) begin
            hz = m_haz(i, lod, rd, ra, rb, imm);
            e_ena[i] = (rst && iack && dok && (m_state[i] == 3 || !hz)) ? 1 : 0;
            if (!dok)                        nxt[i] = 2;
            else if (!iack)                  nxt[i] = 1;
            else if (hz && m_state[i] != 3)  nxt[i] = 3;
            else                             nxt[i] = 0;
        end
        check_outputs("cyc", e_ena);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] = nxt[i];
                m_stb[i]   = 1'b1;
                if (e_ena[i] == 1) begin
                    br_log[i][m_cnt[i] % LOGN] = (bra == 2'b10);
                    m_cnt[i]++;
                end
            end
        end
    endtask

    // Asynchronous reset pulse in mid-cycle with both acks high.
    task automatic pulse_reset(input string pfx);
        int zero_ena [2];
        zero_ena = '{0, 0};
        @(negedge clk);
        #1;
        check_eq({pfx, "_pre_state0"}, bus0.state_o, m_state[0]);
        check_eq({pfx, "_pre_state1"}, bus1.state_o, m_state[1]);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs(pfx, zero_ena);
        @(posedge clk);
        #1;
        check_outputs({pfx, "_hold"}, zero_ena);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    endtask

    initial begin
        int zero_ena [2];
        zero_ena = '{0, 0};
        model_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("init", zero_ena);
        #1;
        rst = 1'b1;

        // Free running after reset: phase alternates on TXE=1.
        repeat (4) idle();

        // Data access held for three cycles, then acknowledged.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        repeat (2) idle();

        // Load-use on rA: one bubble only while EX stays frozen.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 2'b00);
        idle();
        // r0 destination and immediate-masked rB never stall.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 2'b00);
        // Same rB match without immediate does stall.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 2'b00);
        idle();

        // Single taken branch, then back-to-back ones.
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10);
        repeat (4) idle();
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        repeat (3) idle();

        // Fetch and data waits together, then reset mid-wait.
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        pulse_reset("rstw");
        repeat (3) idle();

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rstr");
            end else begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1,
                     2'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
